// File: rtl/sdram_rd_prefetch_if.sv
// Bus bundle for sdram_rd_prefetch: command side, read-wrapper side and
// output stream. The prefetcher connects through the slave modport.
interface sdram_rd_prefetch_if #(
    parameter int SDRAM_W = 128,
    parameter int DEPTH   = 64,
    parameter int LEN_W   = 16
) ();
    logic                   cmd_start;
    logic [31:0]            cmd_addr;
    logic [LEN_W-1:0]       cmd_len;
    logic                   busy;
    logic                   done;
    logic                   read_start;
    logic [31:0]            read_addr;
    logic [10:0]            read_cnt;
    logic                   read_valid;
    logic [SDRAM_W-1:0]     read_data;
    logic                   read_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [SDRAM_W-1:0]     out_data;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf_err;

    modport slave (
        input  cmd_start, cmd_addr, cmd_len,
        input  read_valid, read_data, read_done,
        input  out_ready,
        output busy, done,
        output read_start, read_addr, read_cnt,
        output out_valid, out_data, level, ovf_err
    );

    modport master (
        output cmd_start, cmd_addr, cmd_len,
        output read_valid, read_data, read_done,
        output out_ready,
        input  busy, done,
        input  read_start, read_addr, read_cnt,
        input  out_valid, out_data, level, ovf_err
    );
endinterface

// File: rtl/sdram_rd_prefetch.sv
// Read prefetcher: splits a long read command into wrapper bursts, only
// issuing a burst when the FIFO has room reserved for all of its beats,
// and streams the returned beats out first-word-fall-through.
module sdram_rd_prefetch #(
    parameter int SDRAM_W   = 128,
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sdram_rd_prefetch_if.slave  bus
);
    localparam int          PTR_W      = $clog2(DEPTH);
    localparam int          LVL_W      = PTR_W + 1;
    localparam int          CNT_W      = 11;
    localparam logic [31:0] BEAT_BYTES = 32'(SDRAM_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t             state;
    logic [31:0]        addr;
    logic [LEN_W-1:0]   rem;
    logic [CNT_W-1:0]   cur_burst;
    logic [CNT_W-1:0]   pend;
    logic [CNT_W-1:0]   pend_after;
    logic [CNT_W-1:0]   burst_len;
    logic               credit_ok;

    logic               busy_q;
    logic               done_q;
    logic               start_q;
    logic [31:0]        raddr_q;
    logic [CNT_W-1:0]   rcnt_q;
    logic               ovf_q;

    logic [SDRAM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic               not_empty;
    logic               full;
    logic               push;
    logic               pop;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign pop       = not_empty && bus.out_ready;
    // A beat arriving on a full FIFO is only accepted if the head leaves in the same cycle.
    assign push      = bus.read_valid && (!full || pop);

    // Outstanding reservation after this cycle's arriving beat is accounted for.
    assign pend_after = (bus.read_valid && pend != '0) ? pend - CNT_W'(1) : pend;

    // Next burst is the remaining length clipped to the wrapper's maximum burst.
    always_comb begin
        burst_len = CNT_W'(MAX_BURST);
        if (32'(rem) < 32'(MAX_BURST)) begin
            burst_len = CNT_W'(rem);
        end
    end

    // Room left after counting both stored beats and beats already requested.
    assign credit_ok = (32'(DEPTH) >= 32'(level_q) + 32'(pend) + 32'(burst_len));

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.read_data;
        end
    end

    // Command sequencer with registered wrapper controls, status and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            cur_burst <= '0;
            pend      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            pend    <= pend_after;
            if (bus.read_valid && full && !pop) begin
                ovf_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        addr   <= bus.cmd_addr & ~32'hF;
                        rem    <= bus.cmd_len;
                        busy_q <= 1'b1;
                        state  <= (bus.cmd_len == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (credit_ok) begin
                        start_q   <= 1'b1;
                        raddr_q   <= addr;
                        rcnt_q    <= burst_len;
                        cur_burst <= burst_len;
                        pend      <= burst_len;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.read_done) begin
                        addr <= addr + 32'(cur_burst) * BEAT_BYTES;
                        rem  <= rem - LEN_W'(cur_burst);
                        if (pend_after != '0) begin
                            ovf_q <= 1'b1;
                        end
                        state <= (32'(rem) == 32'(cur_burst)) ? FIN : ISSUE;
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.read_start = start_q;
    assign bus.read_addr  = raddr_q;
    assign bus.read_cnt   = rcnt_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.out_valid  = not_empty;
    assign bus.out_data   = not_empty ? mem[rd_ptr] : '0;
    assign bus.level      = level_q;
endmodule

// File: tb/tb_sdram_rd_prefetch.sv
// Directed bench for sdram_rd_prefetch with a behavioural read-wrapper model.
module tb_sdram_rd_prefetch;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sdram_rd_prefetch_if #(.SDRAM_W(128), .DEPTH(64), .LEN_W(16)) bus ();

    sdram_rd_prefetch #(.SDRAM_W(128), .DEPTH(64), .MAX_BURST(16), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic         mdl_valid;
    logic         mdl_done;
    logic [127:0] mdl_data;
    logic         inj_valid;
    logic [127:0] inj_data;

    logic [31:0]  ba_q [$];
    logic [10:0]  bc_q [$];
    logic [127:0] od_q [$];
    int           done_cnt = 0;

    assign bus.read_valid = mdl_valid | inj_valid;
    assign bus.read_data  = mdl_valid ? mdl_data : inj_data;
    assign bus.read_done  = mdl_done;

    function automatic logic [127:0] make_beat(input logic [31:0] a);
        return {~a, a ^ 32'hA5A5_5A5A, a + 32'h0101_0101, a};
    endfunction

    // Read wrapper: answers each burst request with consecutive beats, then read_done.
    initial begin : wrapper_model
        logic [31:0] baddr;
        logic [10:0] bcnt;
        mdl_valid = 1'b0;
        mdl_done  = 1'b0;
        mdl_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.read_start) begin
                baddr = bus.read_addr;
                bcnt  = bus.read_cnt;
                @(posedge clk); #1;
                for (int i = 0; i < int'(bcnt); i++) begin
                    @(posedge clk); #1;
                    if (!rst_n) break;
                    mdl_valid = 1'b1;
                    mdl_data  = make_beat(baddr + 32'(i) * 32'd16);
                end
                if (rst_n) begin
                    @(posedge clk); #1;
                    mdl_valid = 1'b0;
                    mdl_done  = 1'b1;
                    @(posedge clk); #1;
                    mdl_done  = 1'b0;
                end else begin
                    mdl_valid = 1'b0;
                end
            end
        end
    end

    // Records issued bursts, popped beats and done pulses for later checking.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.read_start) begin
                ba_q.push_back(bus.read_addr);
                bc_q.push_back(bus.read_cnt);
            end
            if (bus.out_valid && bus.out_ready) begin
                od_q.push_back(bus.out_data);
            end
            if (bus.done) begin
                done_cnt++;
            end
        end
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [15:0] len);
        @(posedge clk); #1;
        bus.cmd_start = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},       128'(bus.busy),       128'(0));
        check_output({tag, "_done"},       128'(bus.done),       128'(0));
        check_output({tag, "_read_start"}, 128'(bus.read_start), 128'(0));
        check_output({tag, "_read_addr"},  128'(bus.read_addr),  128'(0));
        check_output({tag, "_read_cnt"},   128'(bus.read_cnt),   128'(0));
        check_output({tag, "_out_valid"},  128'(bus.out_valid),  128'(0));
        check_output({tag, "_out_data"},   bus.out_data,         128'(0));
        check_output({tag, "_level"},      128'(bus.level),      128'(0));
        check_output({tag, "_ovf_err"},    128'(bus.ovf_err),    128'(0));
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(tag, 128'(done_cnt), 128'(target));
    endtask

    task automatic wait_level(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(bus.level) != target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(tag, 128'(bus.level), 128'(target));
    endtask

    task automatic wait_bursts(input string tag, input int target, input int budget);
        int n = 0;
        while (ba_q.size() < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(tag, 128'(ba_q.size()), 128'(target));
    endtask

    // Expected burst plan: chunks of at most 16 beats, 256 bytes apart.
    task automatic check_bursts(input string tag, input int b0, input logic [31:0] base, input int len);
        int          rem = len;
        logic [31:0] a   = base;
        int          k   = 0;
        int          b;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            if (b0 + k < ba_q.size()) begin
                check_output({tag, "_addr"}, 128'(ba_q[b0 + k]), 128'(a));
                check_output({tag, "_cnt"},  128'(bc_q[b0 + k]), 128'(b));
            end
            a   = a + 32'(b * 16);
            rem = rem - b;
            k++;
        end
        check_output({tag, "_nbursts"}, 128'(ba_q.size() - b0), 128'(k));
    endtask

    task automatic check_stream(input string tag, input int o0, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (o0 + k < od_q.size()) begin
                check_output({tag, "_beat"}, od_q[o0 + k], make_beat(base + 32'(k * 16)));
            end
        end
        check_output({tag, "_nbeats"}, 128'(od_q.size() - o0), 128'(n));
    endtask

    initial begin : stimulus
        int b0;
        int o0;
        int d0;

        rst_n         = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
        inj_valid     = 1'b0;
        inj_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;

        $display("[TB] 40-beat command, consumer always ready");
        b0 = ba_q.size(); o0 = od_q.size(); d0 = done_cnt;
        bus.out_ready = 1'b1;
        apply_stimulus(32'h2000_0000, 16'd40);
        check_output("t1_busy", 128'(bus.busy), 128'(1));
        wait_done("t1_done", d0 + 1, 400);
        wait_level("t1_drain", 0, 200);
        check_bursts("t1", b0, 32'h2000_0000, 40);
        check_stream("t1", o0, 32'h2000_0000, 40);
        check_output("t1_one_done", 128'(done_cnt - d0), 128'(1));
        check_output("t1_busy_end", 128'(bus.busy), 128'(0));
        check_output("t1_ovf", 128'(bus.ovf_err), 128'(0));

        $display("[TB] zero-length command");
        b0 = ba_q.size(); d0 = done_cnt;
        apply_stimulus(32'h1234_5670, 16'd0);
        check_output("t3_done_c1", 128'(bus.done), 128'(0));
        check_output("t3_busy_c1", 128'(bus.busy), 128'(1));
        @(posedge clk); #1;
        check_output("t3_done_c2", 128'(bus.done), 128'(1));
        check_output("t3_busy_c2", 128'(bus.busy), 128'(0));
        @(posedge clk); #1;
        check_output("t3_done_c3", 128'(bus.done), 128'(0));
        repeat (5) @(posedge clk);
        #1;
        check_output("t3_no_burst", 128'(ba_q.size() - b0), 128'(0));
        check_output("t3_one_done", 128'(done_cnt - d0), 128'(1));

        $display("[TB] second cmd_start while busy");
        b0 = ba_q.size(); o0 = od_q.size(); d0 = done_cnt;
        apply_stimulus(32'h2000_0000, 16'd40);
        wait_bursts("t4_first_burst", b0 + 1, 50);
        apply_stimulus(32'h5555_0000, 16'd7);
        check_output("t4_busy", 128'(bus.busy), 128'(1));
        wait_done("t4_done", d0 + 1, 400);
        wait_level("t4_drain", 0, 200);
        repeat (20) @(posedge clk);
        #1;
        check_bursts("t4", b0, 32'h2000_0000, 40);
        check_stream("t4", o0, 32'h2000_0000, 40);
        check_output("t4_one_done", 128'(done_cnt - d0), 128'(1));

        $display("[TB] 100-beat command with stalled consumer");
        b0 = ba_q.size(); o0 = od_q.size(); d0 = done_cnt;
        bus.out_ready = 1'b0;
        apply_stimulus(32'h3000_0000, 16'd100);
        wait_level("t2_level_full", 64, 400);
        repeat (20) @(posedge clk);
        #1;
        check_output("t2_stall_bursts", 128'(ba_q.size() - b0), 128'(4));
        check_output("t2_stall_level", 128'(bus.level), 128'(64));
        check_output("t2_stall_busy", 128'(bus.busy), 128'(1));
        bus.out_ready = 1'b1;
        wait_done("t2_done", d0 + 1, 600);
        wait_level("t2_drain", 0, 200);
        check_bursts("t2", b0, 32'h3000_0000, 100);
        check_stream("t2", o0, 32'h3000_0000, 100);
        check_output("t2_ovf", 128'(bus.ovf_err), 128'(0));

        $display("[TB] address wrap at 2^32 and low-bit masking");
        b0 = ba_q.size(); o0 = od_q.size(); d0 = done_cnt;
        apply_stimulus(32'hFFFF_FF8F, 16'd20);
        wait_done("t7_done", d0 + 1, 300);
        wait_level("t7_drain", 0, 200);
        check_bursts("t7", b0, 32'hFFFF_FF80, 20);
        check_stream("t7", o0, 32'hFFFF_FF80, 20);

        $display("[TB] simultaneous push and pop at level 1");
        o0 = od_q.size();
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        inj_valid = 1'b1;
        inj_data  = make_beat(32'h7100_0000);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check_output("t5_lvl1_const", 128'(bus.level), 128'(1));
            bus.out_ready = 1'b1;
            inj_data = make_beat(32'h7100_0000 + 32'(k * 16));
        end
        @(posedge clk); #1;
        check_output("t5_lvl1_end", 128'(bus.level), 128'(1));
        inj_valid = 1'b0;
        wait_level("t5_lvl1_drain", 0, 50);
        check_stream("t5_lvl1", o0, 32'h7100_0000, 9);

        $display("[TB] simultaneous push and pop at level 64, then overflow");
        o0 = od_q.size();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            inj_valid = 1'b1;
            inj_data  = make_beat(32'h7000_0000 + 32'(i * 16));
        end
        @(posedge clk); #1;
        check_output("t5_full", 128'(bus.level), 128'(64));
        for (int k = 0; k < 8; k++) begin
            inj_data      = make_beat(32'h7000_0000 + 32'((64 + k) * 16));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            check_output("t5_lvl64_const", 128'(bus.level), 128'(64));
        end
        bus.out_ready = 1'b0;
        inj_data      = make_beat(32'hDEAD_0000);
        @(posedge clk); #1;
        inj_valid = 1'b0;
        check_output("t5_ovf_level", 128'(bus.level), 128'(64));
        check_output("t5_ovf_set", 128'(bus.ovf_err), 128'(1));
        bus.out_ready = 1'b1;
        wait_level("t5_lvl64_drain", 0, 100);
        check_stream("t5_lvl64", o0, 32'h7000_0000, 72);

        $display("[TB] reset during second burst");
        b0 = ba_q.size(); d0 = done_cnt;
        bus.out_ready = 1'b0;
        apply_stimulus(32'h4000_0000, 16'd40);
        wait_bursts("t6_second_burst", b0 + 2, 200);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = ba_q.size(); o0 = od_q.size(); d0 = done_cnt;
        bus.out_ready = 1'b1;
        apply_stimulus(32'h6000_004C, 16'd8);
        wait_done("t6_done", d0 + 1, 200);
        wait_level("t6_drain", 0, 100);
        check_bursts("t6", b0, 32'h6000_0040, 8);
        check_stream("t6", o0, 32'h6000_0040, 8);
        check_output("t6_ovf", 128'(bus.ovf_err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
